// File: rtl/oled_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : oled_seq_pkg
// Purpose  : Shared types and geometry for the OLED frame sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package oled_seq_pkg;

  localparam int OLED_W = 96;
  localparam int OLED_H = 64;

  typedef logic [15:0] pix_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    GAP   = 2'd3
  } seq_state_t;

  // RGB565 gradient derived from the raster coordinate
  function automatic pix_t test_pattern(input logic [6:0] x, input logic [5:0] y);
    return {x[4:0], y[5:0], x[6:2]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/oled_pix_fifo.sv
`default_nettype none
// ============================================================================
// Module   : oled_pix_fifo
// Purpose  : Small DEPTH-entry FIFO carrying {last, pixel} with occupancy.
// Revision : 1.0 - initial release
// ============================================================================
module oled_pix_fifo #(
  parameter int  DEPTH = 2,
  parameter int  DW    = 17,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_wr_en,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_rd_en,
  output logic [DW-1:0] o_rd_data,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_wr;
  logic          w_rd;

  assign w_rd = i_rd_en && (r_count != '0);
  assign w_wr = i_wr_en && ((r_count != CW'(DEPTH)) || w_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_wr_data;
        r_wr_ptr        <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;

endmodule
`default_nettype wire

// File: rtl/oled_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : oled_frame_sequencer
// Purpose  : Raster scan of 96x64 frames from a font source into a
//            valid/ready pixel stream; single-shot or continuous with gap.
// Options  : OLED_SEQ_TEST_PATTERN_EN - replace i_pixel_in with an RGB565
//            coordinate gradient (timing unchanged).
// Revision : 1.0 - initial release
// ============================================================================
module oled_frame_sequencer
  import oled_seq_pkg::*;
#(
  parameter int  WIDTH       = OLED_W,
  parameter int  HEIGHT      = OLED_H,
  parameter int  SRC_LATENCY = 1,
  parameter int  FRAME_GAP   = 16,
  localparam int XW          = $clog2(WIDTH),
  localparam int YW          = $clog2(HEIGHT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic          i_continuous,
  output logic          o_frame_begin,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  input  pix_t          i_pixel_in,
  output logic          o_pix_valid,
  output pix_t          o_pix_data,
  input  logic          i_pix_ready,
  output logic          o_pix_last,
  output logic          o_frame_done,
  output logic          o_busy
);

  localparam int DEPTH    = SRC_LATENCY + 1;
  localparam int CW       = $clog2(DEPTH + 1);
  localparam int GW       = $clog2(FRAME_GAP + 2);
  localparam int GAP_LOAD = (FRAME_GAP > 0) ? FRAME_GAP - 1 : 0;

  seq_state_t             r_state;
  seq_state_t             w_state_nxt;
  logic [XW-1:0]          r_x;
  logic [YW-1:0]          r_y;
  logic [GW-1:0]          r_gap_cnt;
  logic [SRC_LATENCY-1:0] r_infl_vld;
  logic [SRC_LATENCY-1:0] r_infl_last;
  logic                   r_frame_done;
  logic                   w_issue;
  logic                   w_issue_last;
  logic                   w_pop;
  logic                   w_drained;
  logic                   w_fifo_empty;
  logic [CW-1:0]          w_fifo_count;
  logic [16:0]            w_fifo_rd_data;
  pix_t                   w_cap_pix;

  assign w_issue_last = (r_x == XW'(WIDTH - 1)) && (r_y == YW'(HEIGHT - 1));
  assign w_pop        = !w_fifo_empty && i_pix_ready;
  assign w_drained    = w_fifo_empty && (r_infl_vld == '0);

  // Credit counts the head leaving this cycle so a full-rate stream never bubbles
  assign w_issue = (r_state == SCAN) &&
                   ((int'(w_fifo_count) + $countones(r_infl_vld) - int'(w_pop)) < DEPTH);

  always_comb begin
    w_state_nxt   = r_state;
    o_frame_begin = 1'b0;
    o_busy        = 1'b1;
    case (r_state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start) w_state_nxt = SCAN;
      end
      SCAN: begin
        o_frame_begin = 1'b1;
        if (w_issue && w_issue_last) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_drained) begin
          if (!i_continuous)       w_state_nxt = IDLE;
          else if (FRAME_GAP == 0) w_state_nxt = SCAN;
          else                     w_state_nxt = GAP;
        end
      end
      GAP: begin
        if (r_gap_cnt == '0) w_state_nxt = SCAN;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_gap_cnt    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_frame_done <= w_pop && w_fifo_rd_data[16];
      if ((r_state == IDLE) && i_start) begin
        r_x <= '0;
        r_y <= '0;
      end else if (w_issue) begin
        if (w_issue_last) begin
          r_x <= '0;
          r_y <= '0;
        end else if (r_x == XW'(WIDTH - 1)) begin
          r_x <= '0;
          r_y <= r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end
      if (r_state == DRAIN)
        r_gap_cnt <= GW'(GAP_LOAD);
      else if ((r_state == GAP) && (r_gap_cnt != '0))
        r_gap_cnt <= r_gap_cnt - 1'b1;
    end
  end

  // Newest issue enters bit 0; the top bit lines up with i_pixel_in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_infl_vld  <= '0;
      r_infl_last <= '0;
    end else begin
      r_infl_vld  <= SRC_LATENCY'({r_infl_vld, w_issue});
      r_infl_last <= SRC_LATENCY'({r_infl_last, w_issue && w_issue_last});
    end
  end

`ifdef OLED_SEQ_TEST_PATTERN_EN
  pix_t r_infl_pix [SRC_LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SRC_LATENCY; i++) r_infl_pix[i] <= '0;
    end else begin
      r_infl_pix[0] <= test_pattern(7'(r_x), 6'(r_y));
      for (int i = 1; i < SRC_LATENCY; i++) r_infl_pix[i] <= r_infl_pix[i-1];
    end
  end

  assign w_cap_pix = r_infl_pix[SRC_LATENCY-1];
`else
  assign w_cap_pix = i_pixel_in;
`endif

  oled_pix_fifo #(
    .DEPTH (DEPTH),
    .DW    (17)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (r_infl_vld[SRC_LATENCY-1]),
    .i_wr_data ({r_infl_last[SRC_LATENCY-1], w_cap_pix}),
    .i_rd_en   (w_pop),
    .o_rd_data (w_fifo_rd_data),
    .o_empty   (w_fifo_empty),
    .o_count   (w_fifo_count)
  );

  assign o_x          = r_x;
  assign o_y          = r_y;
  assign o_pix_valid  = !w_fifo_empty;
  assign o_pix_data   = w_fifo_rd_data[15:0];
  assign o_pix_last   = !w_fifo_empty && w_fifo_rd_data[16];
  assign o_frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: doc/oled_frame_sequencer.md
Name: oled_frame_sequencer

Overview:
Raster scan controller for the OLED text path. Generates frame_begin and x/y coordinates for the font pixel source, collects the 16-bit pixel it returns, and streams pixels under a valid/ready handshake to the OLED pixel writer. It sequences whole 96x64 frames (single-shot or continuous) with a programmable inter-frame gap. Sits between the top-level test FSM and the font source / SPI pixel writer pair.

Parameters:
Width, 96, pixels per row.
Height, 64, rows per frame.
SrcLatency, 1, clk cycles from x/y issue to pixel_in valid at the posedge.
FrameGap, 16, idle cycles between frames in continuous mode (0 allowed).

Ports:
clk  in  1  system clock; all state on posedge.
reset  in  1  asynchronous, active-low; asserting low clears all state immediately.
start  in  1  one-cycle pulse; begins a frame from IDLE.
continuous  in  1  1 = repeat frames after the gap, 0 = stop after the current frame.
frame_begin  out  1  enable to the font source; high for the entire issue phase of a frame.
x  out  $clog2(Width)  column issued to the font source.
y  out  $clog2(Height)  row issued to the font source.
pixel_in  in  16  pixel returned by the font source, SrcLatency cycles after issue.
pix_valid  out  1  pix_data holds a pixel.
pix_data  out  16  pixel to the writer.
pix_ready  in  1  writer accepts when pix_valid && pix_ready.
pix_last  out  1  qualifies the final pixel of a frame (x=Width-1, y=Height-1).
frame_done  out  1  one-cycle pulse after the last pixel is accepted.
busy  out  1  high in any state except IDLE.

Behaviour:
- Reset values: frame_begin=0, x=0, y=0, pix_valid=0, pix_data=0, pix_last=0, frame_done=0, busy=0, state=IDLE, buffer empty, in-flight=0.
- States: IDLE, SCAN, DRAIN, GAP.
- IDLE: start=1 -> SCAN, x=y=0. start is ignored in every other state.
- SCAN: frame_begin=1. A coordinate is issued on a cycle when (buffer occupancy + in-flight) < SrcLatency+1. On issue, x increments; at x=Width-1, x wraps to 0 and y increments. Issuing (Width-1,Height-1) -> DRAIN, frame_begin=0, x=y=0 next cycle.
- In-flight tracking: a SrcLatency-deep valid shift register, with pix_last tag, captures pixel_in into the output buffer exactly SrcLatency cycles after issue.
- Output buffer: SrcLatency+1 entry FIFO. Head drives pix_valid, pix_data and pix_last. Credit rule guarantees no overflow. With pix_ready held high, sustained throughput is 1 pixel/clk after SrcLatency fill.
- pix_valid must not deassert and pix_data must not change while pix_ready=0, as in the standard valid/ready protocol.
- DRAIN: wait until the buffer is empty and in-flight=0. Accepting the last pixel pulses frame_done (the cycle after the acceptance edge).
- Leaving DRAIN: continuous=1 -> GAP, with the gap counter loaded with FrameGap. continuous=0 -> IDLE. continuous is sampled only here.
- GAP: counter decrements each cycle; at 0 -> SCAN. FrameGap=0 goes directly to SCAN with no idle cycle beyond the frame_done cycle.
- Clearing continuous mid-GAP has no effect on that gap; it is honoured at the next DRAIN exit.
- Exactly Width*Height pixels per frame; pix_last is asserted on exactly one.
- reset low mid-frame: aborts immediately, buffered pixels are discarded, and no frame_done is generated.

Optional Feature:
OLED_SEQ_TEST_PATTERN_EN
- Defined: pixel_in is ignored. Each captured pixel = {x[4:0], y[5:0], x[6:2]}, computed from the issued coordinate (RGB565 gradient). frame_begin is still driven. Timing is identical.
- Undefined: pixels come from pixel_in.

Decomposition:
- Package oled_seq_pkg: state enum (IDLE, SCAN, DRAIN, GAP); typedef pix_t = logic[15:0]; default geometry constants (OLED_W=96, OLED_H=64).
- One sub-module: oled_pix_fifo, a parameterised depth N, 17-bit wide (data + last) FIFO with occupancy output.

Test Plan:
- start pulse, continuous=0, pix_ready=1 -> 6144 beats, pix_last only on beat 6144, frame_done one cycle after it, busy=0 thereafter; first pix_valid at SrcLatency+1 cycles after start.
- pix_ready toggling pseudo-randomly 50% -> no beat lost or duplicated; pix_data order matches the raster of a scoreboard-modelled font source; pix_data stable while stalled.
- continuous=1, FrameGap=16 -> frame_done to first new frame_begin = 16 cycles; continuous=1, FrameGap=0 -> SCAN immediately after DRAIN.
- start pulsed during SCAN and during GAP -> ignored; frame count unchanged.
- reset driven low at pixel 3000 with buffer full (pix_ready=0) -> all outputs go to reset values asynchronously; no frame_done; the next start restarts at x=0, y=0.
- With OLED_SEQ_TEST_PATTERN_EN: pixel at (x=5, y=2) = 16'h2841; pixel at (95, 63) = 16'hFFF7.
